// File: rtl/led_fade_pwm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_fade_pwm_if                                               |
// | Purpose  : Bundles the four LED on/off requests coming from the blinker  |
// |            and the four PWM-dimmed LED drives plus the busy flag.        |
// | Signals  : i_LED_1..4  on/off request per channel (blinker -> fader)     |
// |            o_LED_1..4  PWM-dimmed LED drive per channel (fader -> pins)  |
// |            o_Busy      high while any channel is still fading            |
// | Modports : master (blinker side), slave (fader side)                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface led_fade_pwm_if;
   logic i_LED_1;
   logic i_LED_2;
   logic i_LED_3;
   logic i_LED_4;
   logic o_LED_1;
   logic o_LED_2;
   logic o_LED_3;
   logic o_LED_4;
   logic o_Busy;

   modport master (
      output i_LED_1, i_LED_2, i_LED_3, i_LED_4,
      input  o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Busy
   );

   modport slave (
      input  i_LED_1, i_LED_2, i_LED_3, i_LED_4,
      output o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Busy
   );
endinterface
`default_nettype wire

// File: rtl/led_fade_pwm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_fade_pwm                                                  |
// | Purpose  : Output stage for the LED blinker. Each of four on/off         |
// |            requests ramps an 8-bit (PWM_BITS) duty up or down one step   |
// |            every STEP_CLKS clocks, and the duty drives a PWM output so   |
// |            the LEDs fade instead of switching hard.                      |
// | Ports    : i_Clock  system clock                                         |
// |            i_Reset  synchronous reset, active-high                       |
// |            bus      led_fade_pwm_if.slave: requests in, LED drives and   |
// |                     busy flag out                                        |
// | Params   : PWM_BITS   PWM counter / duty width, period 2^PWM_BITS clocks |
// |            STEP_CLKS  clocks between duty steps                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module led_fade_pwm #(
   parameter int PWM_BITS  = 8,
   parameter int STEP_CLKS = 48828
) (
   input  wire logic     i_Clock,
   input  wire logic     i_Reset,
   led_fade_pwm_if.slave bus
);

   localparam int                     c_CHANNELS  = 4;
   localparam logic [PWM_BITS-1:0]    c_MAX       = '1;
   localparam logic [PWM_BITS-1:0]    c_DUTY_ONE  = PWM_BITS'(1);
   localparam int                     c_PRE_W     = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
   localparam logic [c_PRE_W-1:0]     c_PRE_LAST  = c_PRE_W'(STEP_CLKS - 1);
   localparam logic [c_PRE_W-1:0]     c_PRE_ONE   = c_PRE_W'(1);

   logic [PWM_BITS-1:0]   r_pwm_count;
   logic [c_PRE_W-1:0]    r_prescale;
   logic                  r_busy;
   logic                  w_step;
   logic                  w_wrap;
   logic [c_CHANNELS-1:0] w_req;
   logic [c_CHANNELS-1:0] w_led;
   logic [c_CHANNELS-1:0] w_off_target;

   assign w_req  = {bus.i_LED_4, bus.i_LED_3, bus.i_LED_2, bus.i_LED_1};
   assign w_step = (r_prescale == c_PRE_LAST);
   assign w_wrap = (r_pwm_count == c_MAX);

   // Shared free-running PWM counter; natural overflow gives the MAX->0 wrap.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_pwm_count <= '0;
      end else begin
         r_pwm_count <= r_pwm_count + c_DUTY_ONE;
      end
   end

   // Shared step prescaler, independent of the PWM counter.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_prescale <= '0;
      end else if (w_step) begin
         r_prescale <= '0;
      end else begin
         r_prescale <= r_prescale + c_PRE_ONE;
      end
   end

   for (genvar g = 0; g < c_CHANNELS; g++) begin : g_channel
      logic [PWM_BITS-1:0] r_duty;    // target duty, ramps one step per strobe
      logic [PWM_BITS-1:0] r_active;  // shadow duty, only changes on the wrap
      logic                r_led;

      always_ff @(posedge i_Clock) begin
         if (i_Reset) begin
            r_duty   <= '0;
            r_active <= '0;
            r_led    <= 1'b0;
         end else begin
            // Saturating ramp; a reversed request simply turns the ramp
            // around from wherever the duty currently is.
            if (w_step) begin
               if (w_req[g]) begin
                  if (r_duty != c_MAX) begin
                     r_duty <= r_duty + c_DUTY_ONE;
                  end
               end else if (r_duty != '0) begin
                  r_duty <= r_duty - c_DUTY_ONE;
               end
            end
            // Loading on the wrap keeps every PWM period glitch-free; when a
            // step coincides with the wrap the pre-step duty is captured.
            if (w_wrap) begin
               r_active <= r_duty;
            end
            // Full duty must be solid on, which count < MAX alone misses.
            r_led <= (r_active == c_MAX) || (r_pwm_count < r_active);
         end
      end

      assign w_led[g]        = r_led;
      assign w_off_target[g] = w_req[g] ? (r_duty != c_MAX) : (r_duty != '0);
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= |w_off_target;
      end
   end

   assign bus.o_LED_1 = w_led[0];
   assign bus.o_LED_2 = w_led[1];
   assign bus.o_LED_3 = w_led[2];
   assign bus.o_LED_4 = w_led[3];
   assign bus.o_Busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_fade_pwm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_led_fade_pwm                                               |
// | Purpose  : Self-checking bench for led_fade_pwm (PWM_BITS=4,             |
// |            STEP_CLKS=4). Directed fade scenarios followed by random      |
// |            requests and resets, compared every clock against a          |
// |            time-indexed reference model.                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_led_fade_pwm;

   localparam int c_PWM_BITS  = 4;
   localparam int c_STEP_CLKS = 4;
   localparam int c_PERIOD    = 1 << c_PWM_BITS;
   localparam int c_MAX       = c_PERIOD - 1;

   logic       r_clk = 1'b0;
   logic       r_rst = 1'b1;
   logic [3:0] r_req = 4'b0000;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: time since reset, per-channel target/active duty.
   int m_time;
   int m_duty   [4];
   int m_active [4];
   bit m_led    [4];
   bit m_busy;

   led_fade_pwm_if u_if ();

   assign u_if.i_LED_1 = r_req[0];
   assign u_if.i_LED_2 = r_req[1];
   assign u_if.i_LED_3 = r_req[2];
   assign u_if.i_LED_4 = r_req[3];

   led_fade_pwm #(
      .PWM_BITS  (c_PWM_BITS),
      .STEP_CLKS (c_STEP_CLKS)
   ) u_dut (
      .i_Clock (r_clk),
      .i_Reset (r_rst),
      .bus     (u_if.slave)
   );

   always #5 r_clk = ~r_clk;

   task automatic check_value(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask

   // One clock edge of the reference behaviour, from values seen before it.
   task automatic model_edge();
      int  pwm;
      bit  step;
      bit  wrap;
      bit  busy_n;
      if (r_rst) begin
         m_time = 0;
         m_busy = 1'b0;
         for (int i = 0; i < 4; i++) begin
            m_duty[i]   = 0;
            m_active[i] = 0;
            m_led[i]    = 1'b0;
         end
      end else begin
         pwm    = m_time % c_PERIOD;
         step   = ((m_time % c_STEP_CLKS) == c_STEP_CLKS - 1);
         wrap   = (pwm == c_MAX);
         busy_n = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (r_req[i]) busy_n |= (m_duty[i] != c_MAX);
            else          busy_n |= (m_duty[i] != 0);
            m_led[i] = (m_active[i] == c_MAX) || (pwm < m_active[i]);
            if (wrap) m_active[i] = m_duty[i];
            if (step) begin
               if (r_req[i]) m_duty[i] = (m_duty[i] < c_MAX) ? m_duty[i] + 1 : c_MAX;
               else          m_duty[i] = (m_duty[i] > 0)     ? m_duty[i] - 1 : 0;
            end
         end
         m_busy = busy_n;
         m_time++;
      end
   endtask

   task automatic compare_outputs();
      logic [3:0] leds;
      leds = {u_if.o_LED_4, u_if.o_LED_3, u_if.o_LED_2, u_if.o_LED_1};
      for (int i = 0; i < 4; i++) begin
         check_value($sformatf("led%0d", i + 1), int'(leds[i]), int'(m_led[i]));
      end
      check_value("busy", int'(u_if.o_Busy), int'(m_busy));
   endtask

   task automatic tick();
      @(posedge r_clk);
      model_edge();
      #1;
      compare_outputs();
   endtask

   task automatic run(input int cycles);
      for (int k = 0; k < cycles; k++) tick();
   endtask

   initial begin
      // Reset, then idle: everything stays dark and not busy.
      r_rst = 1'b1;
      r_req = 4'b0000;
      run(3);
      r_rst = 1'b0;
      run(200);

      // Channel 1 fades fully on and stays solid.
      r_req = 4'b0001;
      run(100);

      // Channel 1 fades out while channel 2 rises for five strobes, then falls.
      r_req = 4'b0010;
      run(20);
      r_req = 4'b0000;
      run(100);

      // Channel 3 part way up, then a single reset cycle mid-fade.
      r_req = 4'b0100;
      run(40);
      r_rst = 1'b1;
      run(1);
      r_rst = 1'b0;
      run(80);

      // Channels 1 and 3 together from reset.
      r_rst = 1'b1;
      r_req = 4'b0101;
      run(1);
      r_rst = 1'b0;
      run(200);

      // Random requests with occasional reversals and resets.
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 39) == 0) r_req[i] = ~r_req[i];
         end
         r_rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      r_rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream output stage for the LED blinker. It takes the four on/off LED levels the blinker produces and drives the physical LEDs.
- Each LED fades smoothly on and off instead of switching hard: an 8-bit duty ramp drives a PWM output.
- Sits between the blinker logic and the board LED pins, in the same clock domain as the blinker.

Parameters:
- PWM_BITS, 8, width of the PWM counter and duty registers; PWM period = 2^PWM_BITS clocks.
- STEP_CLKS, 48828, clocks between duty steps; a full fade is (2^PWM_BITS-1)*STEP_CLKS clocks, about 0.5 s at 25 MHz.

Ports:
- i_Clock  input  1  system clock.
- i_Reset  input  1  synchronous reset, active-high.
- i_LED_1  input  1  on/off request, channel 1 (from blinker).
- i_LED_2  input  1  on/off request, channel 2.
- i_LED_3  input  1  on/off request, channel 3.
- i_LED_4  input  1  on/off request, channel 4.
- o_LED_1  output  1  PWM-dimmed LED drive, channel 1.
- o_LED_2  output  1  PWM-dimmed LED drive, channel 2.
- o_LED_3  output  1  PWM-dimmed LED drive, channel 3.
- o_LED_4  output  1  PWM-dimmed LED drive, channel 4.
- o_Busy  output  1  high while any channel's duty differs from its target.

Behaviour:
- One clock domain, i_Clock. i_Reset is synchronous and active-high. Requests come from the same domain; no synchronisers.
- Reset: every counter, every duty register, all o_LED_n and o_Busy go to 0 on the next edge. Reset overrides all other activity, including mid-fade.
- Define MAX = 2^PWM_BITS-1.
- PWM counter:
  - Free-running, 0..MAX, wraps to 0.
  - "Wrap edge" is the edge where the counter goes MAX->0.
- Step prescaler:
  - Counts 0..STEP_CLKS-1 and wraps.
  - Internal step strobe is high during the cycle the prescaler equals STEP_CLKS-1.
  - Shared by all channels; independent of the PWM counter.
- Per-channel target duty D, PWM_BITS wide, updated on edges where the step strobe is high:
  - request=1 and D<MAX: D<=D+1.
  - request=1 and D=MAX: hold. Saturate, never wrap.
  - request=0 and D>0: D<=D-1.
  - request=0 and D=0: hold.
- Channel state, derived (no extra encoding required): OFF (D=0, req=0), RISING (req=1, D<MAX), ON (D=MAX, req=1), FALLING (req=0, D>0).
- A request reversal mid-fade takes effect at the next step strobe; the ramp continues from the current D with no jump.
- Active duty A:
  - Shadow register, loaded A<=D on the wrap edge only, so duty never changes inside a PWM period (glitch-free).
  - A simultaneous step and wrap loads the pre-step D.
- Output register: o_LED_n <= (A==MAX) OR (pwm_count < A).
  - A=0: constant 0.
  - A=MAX: constant 1.
  - Otherwise: A high cycles per period, starting at count 0.
  - Output is registered, so it lags the counter by one clock.
- o_Busy:
  - Registered OR over channels of (req ? D!=MAX : D!=0).
  - Asserts one clock after a request change that leaves D off-target.
  - Deasserts one clock after the last channel reaches its target.
- Channels are fully independent apart from the shared counters.

Test Plan (PWM_BITS=4, STEP_CLKS=4, so MAX=15):
- Reset, then all requests 0 for 200 clocks -> every o_LED_n=0 and o_Busy=0 throughout.
- i_LED_1 raised and held -> o_Busy=1 on the following clock. D1 reaches 15 after 15 strobes (60 clocks), o_Busy=0 one clock later, and o_LED_1 is constant 1 from the first wrap after that.
- Hold i_LED_1 until D1=8 (8 strobes), then freeze by forcing STEP_CLKS large in a variant build -> after the next wrap, o_LED_1 is high exactly 8 of every 16 clocks, on counts 0..7 (+1 clock lag).
- i_LED_2 high for 5 strobes (D2=5), then low -> D2 steps 4,3,2,1,0 on the next five strobes; o_LED_2 is constant 0 from the first wrap after D2=0; no value above 5 ever appears.
- i_LED_3 fading up with D3=10, assert i_Reset one clock -> next edge all outputs 0, D3=0, prescaler and PWM counter at 0. After release the fade restarts from 0 (first increment 4 clocks later).
- i_LED_1 and i_LED_3 high, i_LED_2 and i_LED_4 low from reset -> only o_LED_1 and o_LED_3 ever pulse, with identical waveforms; o_LED_2 and o_LED_4 stay 0.
